regfile_write_arbiter: RTL

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_write_arbiter_pkg.sv | 13 +
 rtl/rr_arbiter2.sv | 49 ++++
 rtl/regfile_write_arbiter.sv | 97 +++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared processor definitions: register file geometry and write-arbitration state encoding.
package regfile_write_arbiter_pkg;

    localparam int unsigned RegDataW = 8;
    localparam int unsigned RegAddrW = 3;
    localparam int unsigned CountW   = 8;

    typedef enum logic {
        StPri0 = 1'b0,
        StPri1 = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: the requester just granted loses priority on the next tie.
module rr_arbiter2
    import regfile_write_arbiter_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic valid0_i,
    input  logic valid1_i,
    input  logic flush_i,
    output logic grant0_o,
    output logic grant1_o
);

    arb_state_e state_q, state_d;

    always_comb begin
        grant0_o = 1'b0;
        grant1_o = 1'b0;
        if (!flush_i) begin
            if (valid0_i && valid1_i) begin
                grant0_o = (state_q == StPri0);
                grant1_o = (state_q == StPri1);
            end else begin
                grant0_o = valid0_i;
                grant1_o = valid1_i;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = StPri0;
        end else if (grant0_o) begin
            state_d = StPri1;
        end else if (grant1_o) begin
            state_d = StPri0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StPri0;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates ALU and load-unit writebacks onto the single register file write port.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = RegDataW,
    parameter int unsigned ADDR_W = RegAddrW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              flush,
    output logic [ADDR_W-1:0] INaddr,
    output logic [DATA_W-1:0] IN,
    output logic              wr_en,
    output logic              last_grant,
    output logic [CountW-1:0] write_count
);

    localparam logic [CountW-1:0] CountMax = '1;

    logic grant0, grant1;
    logic accept0, accept1, accept;

    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              last_q, last_d;
    logic [CountW-1:0] count_q, count_d;

    rr_arbiter2 u_arb (
        .clk      (clk),
        .reset    (reset),
        .valid0_i (req0_valid),
        .valid1_i (req1_valid),
        .flush_i  (flush),
        .grant0_o (grant0),
        .grant1_o (grant1)
    );

    // Reset gating keeps ready low while an asynchronous reset is discarding the write.
    assign accept0 = req0_valid && grant0 && !flush && !reset;
    assign accept1 = req1_valid && grant1 && !flush && !reset;
    assign accept  = accept0 || accept1;

    assign req0_ready = accept0;
    assign req1_ready = accept1;

    always_comb begin
        wr_en_d = accept;
        addr_d  = addr_q;
        data_d  = data_q;
        last_d  = last_q;
        count_d = count_q;
        if (accept1) begin
            addr_d = req1_addr;
            data_d = req1_data;
            last_d = 1'b1;
        end else if (accept0) begin
            addr_d = req0_addr;
            data_d = req0_data;
            last_d = 1'b0;
        end
        if (accept && (count_q != CountMax)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_en_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            count_q <= '0;
        end else begin
            wr_en_q <= wr_en_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            last_q  <= last_d;
            count_q <= count_d;
        end
    end

    assign wr_en       = wr_en_q;
    assign INaddr      = addr_q;
    assign IN          = data_q;
    assign last_grant  = last_q;
    assign write_count = count_q;

endmodule
